// File: rtl/hamming_sequencer.sv
// Sequences an external Hamming ALU through one parity step and two result steps.
// Encode builds a 16-bit SECDED codeword; decode corrects a received word.
module hamming_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       mode,
  input  logic [7:0] din_lsb,
  input  logic [7:0] din_msb,
  input  logic [7:0] alu_out,
  output logic [3:0] alu_op,
  output logic [7:0] rlsb,
  output logic [7:0] rmsb,
  output logic [7:0] rpct,
  output logic       busy,
  output logic       done,
  output logic [7:0] dout_lsb,
  output logic [7:0] dout_msb
);

  localparam logic [3:0] OpNop = 4'b0000;
  localparam logic [3:0] OpHgp = 4'b0111;
  localparam logic [3:0] OpHel = 4'b1000;
  localparam logic [3:0] OpHem = 4'b1001;
  localparam logic [3:0] OpHep = 4'b1010;
  localparam logic [3:0] OpHcl = 4'b1011;
  localparam logic [3:0] OpHcm = 4'b1100;

  typedef enum logic [2:0] {StIdle, StPar, StLow, StHigh, StDone} state_e;

  state_e state_q;
  logic   mode_q;

  // alu_op/busy/done are loaded with the value belonging to the state being entered,
  // so every output comes straight from a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      mode_q   <= 1'b0;
      rlsb     <= '0;
      rmsb     <= '0;
      rpct     <= '0;
      dout_lsb <= '0;
      dout_msb <= '0;
      alu_op   <= OpNop;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            rlsb    <= din_lsb;
            rmsb    <= din_msb;
            rpct    <= '0;
            mode_q  <= mode;
            alu_op  <= mode ? OpHep : OpHgp;
            busy    <= 1'b1;
            state_q <= StPar;
          end
        end
        StPar: begin
          rpct    <= alu_out;
          alu_op  <= mode_q ? OpHcl : OpHel;
          state_q <= StLow;
        end
        StLow: begin
          dout_lsb <= alu_out;
          alu_op   <= mode_q ? OpHcm : OpHem;
          state_q  <= StHigh;
        end
        StHigh: begin
          dout_msb <= alu_out;
          alu_op   <= OpNop;
          busy     <= 1'b0;
          done     <= 1'b1;
          state_q  <= StDone;
        end
        StDone: begin
          done    <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          alu_op  <= OpNop;
          busy    <= 1'b0;
          done    <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hamming_sequencer.sv
// Bench for hamming_sequencer with a behavioural (16,11) SECDED ALU attached.
// Directed vectors with hand-computed codewords, plus multi-cycle corner sequences.
module tb_hamming_sequencer;

  logic       clk = 1'b0;
  logic       rst_n, start, mode;
  logic [7:0] din_lsb, din_msb, alu_out;
  logic [3:0] alu_op;
  logic [7:0] rlsb, rmsb, rpct, dout_lsb, dout_msb;
  logic       busy, done;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hamming_sequencer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .mode     (mode),
    .din_lsb  (din_lsb),
    .din_msb  (din_msb),
    .alu_out  (alu_out),
    .alu_op   (alu_op),
    .rlsb     (rlsb),
    .rmsb     (rmsb),
    .rpct     (rpct),
    .busy     (busy),
    .done     (done),
    .dout_lsb (dout_lsb),
    .dout_msb (dout_msb)
  );

  // ALU: codeword bit k sits at Hamming position k; rpct = {3'b0, syndrome[3:0], overall parity}.
  function automatic logic [15:0] place_data(input logic [7:0] l, input logic [7:0] m);
    logic [15:0] c;
    c = '0;
    c[3] = l[0]; c[5] = l[1]; c[6] = l[2]; c[7] = l[3];
    c[9] = l[4]; c[10] = l[5]; c[11] = l[6]; c[12] = l[7];
    c[13] = m[0]; c[14] = m[1]; c[15] = m[2];
    return c;
  endfunction

  function automatic logic [3:0] syn16(input logic [15:0] c);
    logic [3:0] s;
    s = '0;
    for (int i = 1; i < 16; i++) if (c[i]) s ^= 4'(i);
    return s;
  endfunction

  function automatic logic [15:0] fix(input logic [15:0] c, input logic [3:0] s);
    logic [15:0] r;
    r = c;
    if (s != 4'd0) r[s] = ~r[s];
    return r;
  endfunction

  logic [15:0] alu_c;
  logic [3:0]  alu_s;

  always_comb begin
    alu_out = '0;
    alu_c   = '0;
    alu_s   = '0;
    case (alu_op)
      4'b0111: begin
        alu_c   = place_data(rlsb, rmsb);
        alu_s   = syn16(alu_c);
        alu_out = {3'b000, alu_s, (^alu_c) ^ (^alu_s)};
      end
      4'b1000: alu_out = {rlsb[3:1], rpct[3], rlsb[0], rpct[2:0]};
      4'b1001: alu_out = {rmsb[2:0], rlsb[7:4], rpct[4]};
      4'b1010: begin
        alu_c   = {rmsb, rlsb};
        alu_s   = syn16(alu_c);
        alu_out = {3'b000, alu_s, ^alu_c};
      end
      4'b1011: begin
        alu_c   = fix({rmsb, rlsb}, rpct[4:1]);
        alu_out = {alu_c[12:9], alu_c[7:5], alu_c[3]};
      end
      4'b1100: begin
        alu_c   = fix({rmsb, rlsb}, rpct[4:1]);
        alu_out = {(rpct[4:1] != 4'd0) && !rpct[0], 4'b0000, alu_c[15:13]};
      end
      default: ;
    endcase
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issues one operation, scrambles inputs after accept, returns edges from accept to done.
  task automatic run_op(input logic md, input logic [7:0] l, input logic [7:0] m,
                        output int edges);
    logic [3:0] exp_op [3];
    exp_op[0] = md ? 4'b1010 : 4'b0111;
    exp_op[1] = md ? 4'b1011 : 4'b1000;
    exp_op[2] = md ? 4'b1100 : 4'b1001;
    @(negedge clk);
    mode = md; din_lsb = l; din_msb = m; start = 1'b1;
    @(negedge clk);
    start = 1'b0; din_lsb = ~l; din_msb = ~m; mode = ~md;
    edges = -1;
    for (int e = 0; e < 10; e++) begin
      if (done) begin
        edges = e;
        break;
      end
      if (e < 3) begin
        check("op_step", 16'(alu_op), 16'(exp_op[e]));
        check("busy_step", 16'(busy), 16'd1);
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 12; k++) begin
      if (!busy && !done) return;
      @(negedge clk);
    end
    check("idle_timeout", 16'(busy), 16'd0);
  endtask

  typedef struct {
    logic       md;
    logic [7:0] l, m, e_rpct, e_lsb, e_msb;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int edges;
    int ndone;
    int first_idx, second_idx;
    logic chk_next;

    vecs[0] = '{1'b0, 8'hA9, 8'h07, 8'h1C, 8'h9C, 8'hF5};  // encode
    vecs[1] = '{1'b1, 8'hD1, 8'h32, 8'h1B, 8'h9C, 8'h00};  // single error at position 13
    vecs[2] = '{1'b1, 8'h40, 8'h04, 8'h18, 8'hA4, 8'h80};  // double error flagged
    vecs[3] = '{1'b0, 8'hFF, 8'h07, 8'h1F, 8'hFF, 8'hFF};  // all-ones data
    vecs[4] = '{1'b1, 8'hFF, 8'hFF, 8'h00, 8'hFF, 8'h07};  // clean all-ones codeword

    rst_n = 1'b1; start = 1'b0; mode = 1'b0; din_lsb = '0; din_msb = '0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_done", 16'(done), 16'd0);
    check("rst_op", 16'(alu_op), 16'd0);
    check("rst_regs", {rlsb, rmsb}, 16'h0000);
    check("rst_rpct", 16'(rpct), 16'd0);
    check("rst_dout", {dout_msb, dout_lsb}, 16'h0000);

    // Start presented together with reset release must be taken at the first edge.
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1; start = 1'b1; mode = 1'b0; din_lsb = 8'h12; din_msb = 8'h03;
    @(negedge clk);
    start = 1'b0;
    check("accept_after_reset", 16'(busy), 16'd1);
    check("rlsb_captured", {rmsb, rlsb}, 16'h0312);
    wait_idle();

    for (int v = 0; v < 5; v++) begin
      run_op(vecs[v].md, vecs[v].l, vecs[v].m, edges);
      check("latency", 16'(edges), 16'd3);
      check("rpct", 16'(rpct), 16'(vecs[v].e_rpct));
      check("dout_lsb", 16'(dout_lsb), 16'(vecs[v].e_lsb));
      check("dout_msb", 16'(dout_msb), 16'(vecs[v].e_msb));
      @(negedge clk);
      check("done_one_cycle", {7'd0, done, 7'd0, busy}, 16'h0000);
    end

    // Start pulsed during PAR with different operands must not disturb or queue.
    @(negedge clk);
    mode = 1'b0; din_lsb = 8'hA9; din_msb = 8'h07; start = 1'b1;
    @(negedge clk);
    mode = 1'b1; din_lsb = 8'hFF; din_msb = 8'hFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      if (done) begin
        ndone++;
        check("prot_rpct", 16'(rpct), 16'h001C);
        check("prot_dout", {dout_msb, dout_lsb}, 16'hF59C);
        check("prot_rlsb", 16'(rlsb), 16'h00A9);
      end
      @(negedge clk);
    end
    check("prot_single_done", 16'(ndone), 16'd1);

    // Reset while in LOW aborts with no done pulse afterwards.
    @(negedge clk);
    mode = 1'b1; din_lsb = 8'hD1; din_msb = 8'h32; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 16'(busy), 16'd0);
    check("abort_done", 16'(done), 16'd0);
    check("abort_rpct", 16'(rpct), 16'd0);
    check("abort_dout", {dout_msb, dout_lsb}, 16'h0000);
    check("abort_op", 16'(alu_op), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    check("abort_no_done", 16'(ndone), 16'd0);
    run_op(1'b0, 8'h00, 8'h00, edges);
    check("zero_latency", 16'(edges), 16'd3);
    check("zero_rpct", 16'(rpct), 16'd0);
    check("zero_dout", {dout_msb, dout_lsb}, 16'h0000);
    wait_idle();

    // Held start: one operation every 5 cycles; opcode idle in DONE and IDLE.
    @(negedge clk);
    mode = 1'b0; din_lsb = 8'hA9; din_msb = 8'h07; start = 1'b1;
    ndone = 0; first_idx = -1; second_idx = -1; chk_next = 1'b0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (chk_next) begin
        check("op_in_idle", {alu_op, 3'b000, busy, 8'h00}, 16'h0000);
        chk_next = 1'b0;
      end
      if (done) begin
        check("op_in_done", 16'(alu_op), 16'd0);
        check("b2b_dout", {dout_msb, dout_lsb}, 16'hF59C);
        if (ndone == 0) first_idx = c;
        else second_idx = c;
        ndone++;
        chk_next = 1'b1;
        if (ndone == 2) start = 1'b0;
      end
    end
    start = 1'b0;
    check("b2b_count", 16'(ndone), 16'd2);
    check("b2b_gap", 16'(second_idx - first_idx), 16'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
